mem_read_arbiter: RTL and testbench
===================================

// Module: mem_read_arbiter
// PURPOSE
//   Shares one synchronous-read memory port between two address requesters.
//   Requester 0 is the speed-controlled display address stepper; requester 1 is a debug/dump reader.
//   Per-cycle grant via round-robin or fixed-priority-with-aging, registered address issue,
//   and return-data steering with valid strobes.
// PARAMETERS
//   AW           8   address width
//   DW           32  data width
//   PRIO_MODE    0   0 = round-robin; 1 = req0 fixed priority with req1 aging
//   STARVE_LIMIT 3   PRIO_MODE=1 only: consecutive lost cycles before req1 is forced (1..255)
// PORTS
//   clk        in   1   system clock, all logic on posedge
//   rst_n      in   1   synchronous active-low reset
//   hold       in   1   1 = issue no new grants (in-flight reads still complete)
//   req0       in   1   requester 0 read request, held until granted
//   addr0      in   AW  requester 0 address, stable while req0=1
//   gnt0       out  1   combinational accept; transfer occurs when req0&gnt0 at posedge
//   rvalid0    out  1   rdata belongs to requester 0 this cycle
//   req1       in   1   requester 1 read request
//   addr1      in   AW  requester 1 address
//   gnt1       out  1   combinational accept for requester 1
//   rvalid1    out  1   rdata belongs to requester 1 this cycle
//   mem_en     out  1   registered memory read enable
//   mem_addr   out  AW  registered memory address
//   mem_rdata  in   DW  memory read data, valid the cycle after mem_en
//   rdata      out  DW  = mem_rdata (combinational pass-through)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): mem_en=0, mem_addr=0, rvalid0/1 pipeline cleared, rr_last=1
//     (req0 wins first tie), starve_cnt=0.
//   gnt0/gnt1 are forced 0 during the reset cycle.
//   Reset mid-operation: in-flight reads are discarded; no rvalid is produced for them.
//   Grant (combinational, at most one of gnt0/gnt1 high):
//     - hold=1 or rst_n=0 -> both 0.
//     - Only one req high -> that requester is granted.
//     - Both high, PRIO_MODE=0 -> the requester not equal to rr_last.
//       rr_last updates to the granted id on each transfer.
//     - Both high, PRIO_MODE=1 -> req1 if starve_cnt == STARVE_LIMIT, else req0.
//   Aging counter (PRIO_MODE=1):
//     - starve_cnt increments when req1 & ~gnt1 & ~hold.
//     - Clears on a req1 transfer or when req1=0.
//     - Saturates at STARVE_LIMIT; the counter is 8 bits.
//   Pipeline, for a transfer at posedge T:
//     - Cycle T+1: mem_en=1, mem_addr=addr of granted requester, id registered.
//     - Cycle T+2: rvalidN=1 for that id, rdata=mem_rdata.
//     - Accept-to-data latency is 2 cycles.
//     - One transfer per cycle sustained; back-to-back grants to the same requester are allowed.
//   No transfer at T -> mem_en=0 at T+1 and mem_addr holds its last value.
//   hold rising: grants stop the same cycle; reads already issued still return rvalid.
//   hold does not modify rr_last or starve_cnt.
//   Requester drops req before grant: legal, no transfer, no state change except starve_cnt clear.
//   Address wrap is the requester's concern; addresses pass through unmodified.
// TESTING
//   1. rst_n=0 3 cycles, req0=req1=1: gnt0=gnt1=mem_en=rvalid*=0.
//      At the first cycle after release, gnt0=1.
//   2. Only req0=1, addr0=0x05, mem[5]=0xDEADBEEF, accepted at T:
//      mem_en=1 with mem_addr=0x05 at T+1; rvalid0=1 with rdata=0xDEADBEEF at T+2.
//   3. PRIO_MODE=0, req0 and req1 held for 6 cycles:
//      gnt order 0,1,0,1,0,1; mem_en=1 every cycle; rvalids alternate 2 cycles later.
//   4. PRIO_MODE=1, STARVE_LIMIT=3, both held:
//      gnt pattern 0,0,0,1 repeating, period 4; starve_cnt returns to 0 after each gnt1.
//   5. Both held, hold=1 at T for 2 cycles:
//      gnt low during T and T+1; mem_en low T+1..T+2; reads accepted at T-1 still return rvalid at T+1.
//   6. Transfer at T, rst_n=0 at T+1: no rvalid at T+2; mem_en=0 at T+2.

Source files
------------

// File: rtl/mem_read_arbiter_if.sv
// Bundle of the two requester ports and the synchronous-read memory port
// that mem_read_arbiter sits between.
interface mem_read_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          gnt0;
    logic          rvalid0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic          gnt1;
    logic          rvalid1;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rdata;

    modport slave (
        input  req0, addr0, req1, addr1, mem_rdata,
        output gnt0, rvalid0, gnt1, rvalid1, mem_en, mem_addr, rdata
    );

    modport master (
        output req0, addr0, req1, addr1, mem_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1, mem_en, mem_addr, rdata
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-requester arbiter for one synchronous-read memory port: per-cycle grant
// (round-robin or req0-priority with req1 aging), registered issue, rdata steering.
module mem_read_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 32,
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_hold,
    mem_read_arbiter_if.slave    bus
);
    localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_age_force;
    logic [DW-1:0] w_rdata;

    logic          r_rr_last;
    logic [7:0]    r_starve_cnt;
    logic          r_mem_en;
    logic [AW-1:0] r_mem_addr;
    logic          r_id;
    logic          r_rvalid0;
    logic          r_rvalid1;

    assign w_age_force = (PRIO_MODE != 0) && (r_starve_cnt == LP_LIMIT);

    // Grant decision; r_rr_last=1 means requester 0 wins the next tie.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_rst_n || i_hold) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else if (bus.req0 && bus.req1) begin
            if (PRIO_MODE == 0) begin
                w_gnt0 = r_rr_last;
                w_gnt1 = ~r_rr_last;
            end else begin
                w_gnt0 = ~w_age_force;
                w_gnt1 = w_age_force;
            end
        end else if (bus.req0) begin
            w_gnt0 = 1'b1;
        end else if (bus.req1) begin
            w_gnt1 = 1'b1;
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    // Arbitration state: round-robin pointer and req1 aging counter (hold freezes both).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rr_last    <= 1'b1;
            r_starve_cnt <= 8'd0;
        end else begin
            if (w_gnt0) begin
                r_rr_last <= 1'b0;
            end else if (w_gnt1) begin
                r_rr_last <= 1'b1;
            end else begin
                r_rr_last <= r_rr_last;
            end

            if (PRIO_MODE == 0) begin
                r_starve_cnt <= 8'd0;
            end else if (!bus.req1 || w_gnt1) begin
                r_starve_cnt <= 8'd0;
            end else if (!i_hold && (r_starve_cnt != LP_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end
    end

    // Issue stage then return stage; reset drops anything still in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mem_en   <= 1'b0;
            r_mem_addr <= {AW{1'b0}};
            r_id       <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_mem_en <= w_gnt0 | w_gnt1;
            if (w_gnt0) begin
                r_mem_addr <= bus.addr0;
                r_id       <= 1'b0;
            end else if (w_gnt1) begin
                r_mem_addr <= bus.addr1;
                r_id       <= 1'b1;
            end else begin
                r_mem_addr <= r_mem_addr;
                r_id       <= r_id;
            end
            r_rvalid0 <= r_mem_en & ~r_id;
            r_rvalid1 <= r_mem_en & r_id;
        end
    end

    assign w_rdata      = bus.mem_rdata;
    assign bus.rdata    = w_rdata;
    assign bus.gnt0     = w_gnt0;
    assign bus.gnt1     = w_gnt1;
    assign bus.mem_en   = r_mem_en;
    assign bus.mem_addr = r_mem_addr;
    assign bus.rvalid0  = r_rvalid0;
    assign bus.rvalid1  = r_rvalid1;
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench: DUT 0 runs round-robin, DUT 1 runs req0 priority with
// req1 aging (limit 3); each has its own memory model and request stream.
module tb_mem_read_arbiter;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int LIMIT = 3;

    typedef struct {
        int            due;
        logic          id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          hold;
    logic          r0 [2];
    logic          r1 [2];
    logic [AW-1:0] a0 [2];
    logic [AW-1:0] a1 [2];
    logic          g0 [2];
    logic          g1 [2];
    logic          en [2];
    logic          v0 [2];
    logic          v1 [2];
    logic [AW-1:0] maddr [2];
    logic [DW-1:0] rd [2];
    logic [DW-1:0] mem [256];

    exp_t iq [2][$];
    exp_t dq [2][$];
    int   last_win [2];
    int   lost1 [2];
    int   granted [2];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mem_read_arbiter_if #(.AW(AW), .DW(DW)) ifc0 ();
    mem_read_arbiter_if #(.AW(AW), .DW(DW)) ifc1 ();

    mem_read_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(0), .STARVE_LIMIT(LIMIT)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .bus(ifc0)
    );
    mem_read_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(1), .STARVE_LIMIT(LIMIT)) dut_pr (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .bus(ifc1)
    );

    assign ifc0.req0 = r0[0];  assign ifc0.addr0 = a0[0];
    assign ifc0.req1 = r1[0];  assign ifc0.addr1 = a1[0];
    assign ifc1.req0 = r0[1];  assign ifc1.addr0 = a0[1];
    assign ifc1.req1 = r1[1];  assign ifc1.addr1 = a1[1];
    assign g0[0] = ifc0.gnt0;  assign g1[0] = ifc0.gnt1;
    assign g0[1] = ifc1.gnt0;  assign g1[1] = ifc1.gnt1;
    assign en[0] = ifc0.mem_en;  assign maddr[0] = ifc0.mem_addr;
    assign en[1] = ifc1.mem_en;  assign maddr[1] = ifc1.mem_addr;
    assign v0[0] = ifc0.rvalid0; assign v1[0] = ifc0.rvalid1; assign rd[0] = ifc0.rdata;
    assign v0[1] = ifc1.rvalid0; assign v1[1] = ifc1.rvalid1; assign rd[1] = ifc1.rdata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ifc0.mem_en) ifc0.mem_rdata <= mem[ifc0.mem_addr];
        if (ifc1.mem_en) ifc1.mem_rdata <= mem[ifc1.mem_addr];
    end

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, exp);
        end
    endtask

    // Monitor: every memory issue and every returned word is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (en[d] === 1'b1) begin
                if (iq[d].size() == 0) begin
                    chk("unexpected_mem_en", d, en[d], 0);
                end else begin
                    e = iq[d].pop_front();
                    chk("mem_issue_cycle", d, cyc, e.due);
                    chk("mem_addr", d, maddr[d], e.addr);
                end
            end else if (iq[d].size() != 0 && iq[d][0].due <= cyc) begin
                chk("missing_mem_en", d, en[d], 1);
                void'(iq[d].pop_front());
            end

            if (v0[d] === 1'b1 || v1[d] === 1'b1) begin
                chk("both_rvalid", d, v0[d] & v1[d], 0);
                if (dq[d].size() == 0) begin
                    chk("unexpected_rvalid", d, v0[d] | v1[d], 0);
                end else begin
                    e = dq[d].pop_front();
                    chk("rvalid_cycle", d, cyc, e.due);
                    chk("rvalid_id", d, v1[d], e.id);
                    chk("rdata", d, rd[d], e.data);
                end
            end else if (dq[d].size() != 0 && dq[d][0].due <= cyc) begin
                chk("missing_rvalid", d, v0[d] | v1[d], 1);
                void'(dq[d].pop_front());
            end
        end
    end

    // One clock of stimulus: reference grant for each DUT, scoreboard push, model update.
    task automatic drive_cycle(input logic rst_v, input logic hold_v);
        int            eg;
        exp_t          e;
        logic [AW-1:0] ad;
        rst_n = rst_v;
        hold  = hold_v;
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_v || hold_v) eg = -1;
            else if (r0[d] && r1[d]) begin
                if (d == 0) eg = (last_win[d] == 0) ? 1 : 0;
                else        eg = (lost1[d] == LIMIT) ? 1 : 0;
            end
            else if (r0[d]) eg = 0;
            else if (r1[d]) eg = 1;
            else eg = -1;
            chk("gnt0", d, g0[d], eg == 0);
            chk("gnt1", d, g1[d], eg == 1);
            if (!rst_v) begin
                last_win[d] = 1;
                lost1[d]    = 0;
                iq[d].delete();
                dq[d].delete();
            end else begin
                if (eg >= 0) begin
                    ad     = (eg == 1) ? a1[d] : a0[d];
                    e.id   = (eg == 1);
                    e.addr = ad;
                    e.data = mem[ad];
                    e.due  = cyc + 1;
                    iq[d].push_back(e);
                    e.due  = cyc + 2;
                    dq[d].push_back(e);
                    last_win[d] = eg;
                end
                if (!r1[d] || eg == 1) lost1[d] = 0;
                else if (!hold_v && lost1[d] < LIMIT) lost1[d] = lost1[d] + 1;
            end
            granted[d] = eg;
        end
        @(posedge clk);
        #1;
    endtask

    // Requests stay up until granted (occasionally withdrawn); otherwise a fresh random request.
    task automatic next_reqs();
        for (int d = 0; d < 2; d++) begin
            if (!(r0[d] && granted[d] != 0 && $urandom_range(7) != 0)) begin
                r0[d] = ($urandom_range(9) < 6);
                a0[d] = AW'($urandom);
            end
            if (!(r1[d] && granted[d] != 1 && $urandom_range(7) != 0)) begin
                r1[d] = ($urandom_range(9) < 6);
                a1[d] = AW'($urandom);
            end
        end
    endtask

    task automatic set_reqs(input logic q0, input logic [AW-1:0] x0, input logic q1, input logic [AW-1:0] x1);
        for (int d = 0; d < 2; d++) begin
            r0[d] = q0; a0[d] = x0;
            r1[d] = q1; a1[d] = x1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[5] = 32'hDEADBEEF;
        for (int d = 0; d < 2; d++) begin
            last_win[d] = 1;
            lost1[d]    = 0;
            granted[d]  = -1;
        end
        rst_n = 1'b0;
        hold  = 1'b0;

        set_reqs(1'b1, 8'h10, 1'b1, 8'h20);
        repeat (3) drive_cycle(1'b0, 1'b0);
        repeat (10) drive_cycle(1'b1, 1'b0);

        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b1, 1'b1);
        repeat (3) drive_cycle(1'b1, 1'b0);

        set_reqs(1'b1, 8'h05, 1'b0, 8'h00);
        drive_cycle(1'b1, 1'b0);
        set_reqs(1'b0, 8'h05, 1'b0, 8'h00);
        repeat (3) drive_cycle(1'b1, 1'b0);

        set_reqs(1'b1, 8'h33, 1'b1, 8'h44);
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0);
        set_reqs(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) drive_cycle(1'b1, 1'b0);

        repeat (3000) begin
            next_reqs();
            drive_cycle(($urandom_range(99) != 0), ($urandom_range(9) == 0));
        end

        set_reqs(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (4) drive_cycle(1'b1, 1'b0);
        for (int d = 0; d < 2; d++) chk("scoreboard_drained", d, iq[d].size() + dq[d].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
